// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the
// multiport register file.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_e;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every
// register once, then hands over to RUN.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST =
      AW'(NUM_REGS - 1);

   rf_state_e     state;
   rf_state_e     state_n;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         CLEAR: begin
            if (cnt == LAST) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RUN: begin
            state_n = RUN;
         end
         default: begin
            state_n = CLEAR;
            cnt_n   = '0;
         end
      endcase
   end

   assign busy     = (state == CLEAR);
   assign clr_we   = busy;
   assign clr_addr = cnt;

endmodule

// File: rtl/multiport_reg_file.sv
// Register file with N combinational read
// ports, one core write port and a debug port.
module multiport_reg_file
   import regfile_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int NUM_REGS     = NUM_REGS_DEF,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS       = 1,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD_PORTS-1:0]
                [AW-1:0]          rd_addr,
   output logic [NUM_RD_PORTS-1:0]
                [XLEN-1:0]        rd_data,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [XLEN-1:0]        wr_data,
   input  logic                   dbg_valid,
   output logic                   dbg_ready,
   input  logic                   dbg_we,
   input  logic [AW-1:0]          dbg_addr,
   input  logic [XLEN-1:0]        dbg_wdata,
   output logic [XLEN-1:0]        dbg_rdata,
   output logic                   dbg_rvalid,
   output logic                   busy
);

   localparam logic [AW:0] NREG =
      (AW+1)'(NUM_REGS);

   logic            clr_we;
   logic [AW-1:0]   clr_addr;
   logic [XLEN-1:0] regs [NUM_REGS];

   logic core_we;
   logic dbg_acc;
   logic dbg_wr;
   logic dbg_rd;

   // x0 and out-of-range addresses are
   // neither readable nor writable
   function automatic logic addr_ok(
      input logic [AW-1:0] a
   );
      return (a != '0) &&
             ({1'b0, a} < NREG);
   endfunction

   regfile_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign dbg_ready = !busy && !wr_en;
   assign dbg_acc   = dbg_valid && dbg_ready;
   assign dbg_rd    = dbg_acc && !dbg_we;

   assign core_we = !busy && wr_en &&
                    addr_ok(wr_addr);
   assign dbg_wr  = dbg_acc && dbg_we &&
                    addr_ok(dbg_addr);

   // core and debug never both commit:
   // dbg_ready already excludes wr_en
   always_ff @(posedge clk) begin
      if (clr_we) begin
         regs[clr_addr] <= '0;
      end else if (rst && core_we) begin
         regs[wr_addr] <= wr_data;
      end else if (rst && dbg_wr) begin
         regs[dbg_addr] <= dbg_wdata;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         if (!busy && addr_ok(rd_addr[p])) begin
            if (BYPASS != 0 && wr_en &&
                wr_addr == rd_addr[p]) begin
               rd_data[p] = wr_data;
            end else begin
               rd_data[p] = regs[rd_addr[p]];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         dbg_rvalid <= dbg_rd;
         if (dbg_rd) begin
            dbg_rdata <= addr_ok(dbg_addr) ?
                         regs[dbg_addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Scoreboard bench for multiport_reg_file:
// default, no-bypass and 20-register instances.
module tb_multiport_reg_file;

   localparam int S_BUSY  = 0;
   localparam int S_RD0   = 1;
   localparam int S_RD1   = 2;
   localparam int S_RDY   = 3;
   localparam int S_NRD0  = 4;
   localparam int S_SRD0  = 5;
   localparam int S_SBUSY = 6;
   localparam int S_RVAL  = 7;
   localparam int S_DRD   = 8;
   localparam int S_NBUSY = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst       = 1'b0;
   logic [1:0][4:0]  rd_addr   = '0;
   logic             wr_en     = 1'b0;
   logic [4:0]       wr_addr   = '0;
   logic [31:0]      wr_data   = '0;
   logic             dbg_valid = 1'b0;
   logic             dbg_we    = 1'b0;
   logic [4:0]       dbg_addr  = '0;
   logic [31:0]      dbg_wdata = '0;

   logic [1:0][31:0] m_rd_data, n_rd_data, s_rd_data;
   logic             m_rdy, n_rdy, s_rdy;
   logic [31:0]      m_drd, n_drd, s_drd;
   logic             m_rval, n_rval, s_rval;
   logic             m_busy, n_busy, s_busy;

   multiport_reg_file u_main (
      .clk (clk), .rst (rst),
      .rd_addr (rd_addr), .rd_data (m_rd_data),
      .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_data (wr_data),
      .dbg_valid (dbg_valid), .dbg_ready (m_rdy),
      .dbg_we (dbg_we), .dbg_addr (dbg_addr),
      .dbg_wdata (dbg_wdata), .dbg_rdata (m_drd),
      .dbg_rvalid (m_rval), .busy (m_busy)
   );

   multiport_reg_file #(.BYPASS(0)) u_nb (
      .clk (clk), .rst (rst),
      .rd_addr (rd_addr), .rd_data (n_rd_data),
      .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_data (wr_data),
      .dbg_valid (dbg_valid), .dbg_ready (n_rdy),
      .dbg_we (dbg_we), .dbg_addr (dbg_addr),
      .dbg_wdata (dbg_wdata), .dbg_rdata (n_drd),
      .dbg_rvalid (n_rval), .busy (n_busy)
   );

   multiport_reg_file #(.NUM_REGS(20)) u_sm (
      .clk (clk), .rst (rst),
      .rd_addr (rd_addr), .rd_data (s_rd_data),
      .wr_en (wr_en), .wr_addr (wr_addr),
      .wr_data (wr_data),
      .dbg_valid (dbg_valid), .dbg_ready (s_rdy),
      .dbg_we (dbg_we), .dbg_addr (dbg_addr),
      .dbg_wdata (dbg_wdata), .dbg_rdata (s_drd),
      .dbg_rvalid (s_rval), .busy (s_busy)
   );

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] dbg_q[$];
   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] probe(int sig);
      case (sig)
         S_BUSY:  probe = {31'b0, m_busy};
         S_RD0:   probe = m_rd_data[0];
         S_RD1:   probe = m_rd_data[1];
         S_RDY:   probe = {31'b0, m_rdy};
         S_NRD0:  probe = n_rd_data[0];
         S_SRD0:  probe = s_rd_data[0];
         S_SBUSY: probe = {31'b0, s_busy};
         S_RVAL:  probe = {31'b0, m_rval};
         S_DRD:   probe = m_drd;
         S_NBUSY: probe = {31'b0, n_busy};
         default: probe = 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_v(string name, int sig,
                           logic [31:0] val);
      exp_q.push_back('{cyc, sig, val, name});
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // monitor: debug responses and queued samples
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] d;
      if (m_rval === 1'b1) begin
         checks++;
         if (dbg_q.size() == 0) begin
            errors++;
            $display("FAIL dbg_spurious got rdata=%h required no response",
                     m_drd);
         end else begin
            d = dbg_q.pop_front();
            if (m_drd !== d) begin
               errors++;
               $display("FAIL dbg_rdata got %h required %h",
                        m_drd, d);
            end
         end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s stale sample cyc %0d required cyc %0d",
                     e.name, cyc, e.cyc);
         end else if (probe(e.sig) !== e.val) begin
            errors++;
            $display("FAIL %s got %h required %h",
                     e.name, probe(e.sig), e.val);
         end
      end
   end

   initial begin
      rst = 1'b0;
      step;
      rst = 1'b1;
      expect_v("rst_drd", S_DRD, 32'h0);
      expect_v("rst_rval", S_RVAL, 32'h0);
      // writes and debug traffic during CLEAR must be ignored
      wr_addr    = 5'd7;
      wr_data    = 32'h77;
      rd_addr[0] = 5'd7;
      rd_addr[1] = 5'd7;
      dbg_we     = 1'b1;
      dbg_addr   = 5'd8;
      dbg_wdata  = 32'h88;
      for (int i = 0; i < 32; i++) begin
         wr_en     = (i < 16);
         dbg_valid = (i < 18);
         expect_v("clr_busy", S_BUSY, 32'h1);
         expect_v("clr_nbusy", S_NBUSY, 32'h1);
         expect_v("clr_rdy", S_RDY, 32'h0);
         expect_v("clr_rd0", S_RD0, 32'h0);
         expect_v("sm_busy", S_SBUSY, (i < 20) ? 32'h1 : 32'h0);
         step;
      end
      wr_en     = 1'b0;
      dbg_valid = 1'b0;
      expect_v("run_busy", S_BUSY, 32'h0);
      expect_v("run_rdy", S_RDY, 32'h1);
      for (int i = 0; i < 32; i++) begin
         rd_addr[0] = 5'(i);
         rd_addr[1] = 5'(31 - i);
         expect_v("zero_rd0", S_RD0, 32'h0);
         expect_v("zero_rd1", S_RD1, 32'h0);
         step;
      end
      // x3 = 10, bypass and plain read
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd10;
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
      expect_v("x3_byp", S_RD0, 32'd10);
      expect_v("x3_nbyp", S_NRD0, 32'd0);
      expect_v("x3_rdy", S_RDY, 32'h0);
      step;
      wr_en = 1'b0;
      expect_v("x3_rd0", S_RD0, 32'd10);
      expect_v("x3_rd1", S_RD1, 32'd10);
      expect_v("x3_nrd0", S_NRD0, 32'd10);
      step;
      // x0 stays zero
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF;
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
      expect_v("x0_byp", S_RD0, 32'h0);
      step;
      wr_en = 1'b0;
      expect_v("x0_rd0", S_RD0, 32'h0);
      expect_v("x0_rd1", S_RD1, 32'h0);
      step;
      // x5 = 5, bypass versus no bypass
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd5;
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd3;
      expect_v("x5_byp", S_RD0, 32'd5);
      expect_v("x5_nbyp", S_NRD0, 32'd0);
      expect_v("x5_rd1", S_RD1, 32'd10);
      step;
      wr_en = 1'b0;
      expect_v("x5_rd0", S_RD0, 32'd5);
      expect_v("x5_nrd0", S_NRD0, 32'd5);
      step;
      // 20-register instance: address 25 out of range
      wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h55;
      rd_addr[0] = 5'd25;
      expect_v("a25_main", S_RD0, 32'h55);
      expect_v("a25_sm_byp", S_SRD0, 32'h0);
      step;
      wr_addr = 5'd19; wr_data = 32'h19;
      expect_v("a25_main_rd", S_RD0, 32'h55);
      expect_v("a25_sm_rd", S_SRD0, 32'h0);
      step;
      wr_en = 1'b0; rd_addr[0] = 5'd19;
      expect_v("a19_sm", S_SRD0, 32'h19);
      expect_v("a19_main", S_RD0, 32'h19);
      step;
      // debug write stalled by core writes
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd44;
      dbg_valid = 1'b1; dbg_we = 1'b1;
      dbg_addr = 5'd9; dbg_wdata = 32'd60;
      rd_addr[0] = 5'd9;
      expect_v("dbg_stall0", S_RDY, 32'h0);
      expect_v("dbg_x9_old", S_RD0, 32'h0);
      step;
      expect_v("dbg_stall1", S_RDY, 32'h0);
      step;
      wr_en = 1'b0;
      expect_v("dbg_acc_rdy", S_RDY, 32'h1);
      expect_v("dbg_no_byp", S_RD0, 32'h0);
      step;
      // back-to-back debug reads
      dbg_we = 1'b0; dbg_addr = 5'd9;
      expect_v("dbg_x9_new", S_RD0, 32'd60);
      dbg_q.push_back(32'd60);
      step;
      dbg_addr = 5'd0;
      expect_v("dbg_rval1", S_RVAL, 32'h1);
      dbg_q.push_back(32'd0);
      step;
      dbg_addr = 5'd4;
      dbg_q.push_back(32'd44);
      step;
      dbg_valid = 1'b0;
      step;
      expect_v("dbg_rval0", S_RVAL, 32'h0);
      expect_v("dbg_hold0", S_DRD, 32'd44);
      step;
      expect_v("dbg_hold1", S_DRD, 32'd44);
      step;
      // reset in RUN drops a read accepted at that edge
      rst = 1'b0;
      dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
      expect_v("pre_rst_busy", S_BUSY, 32'h0);
      step;
      rst = 1'b1; dbg_valid = 1'b0;
      expect_v("rst_drd_clr", S_DRD, 32'h0);
      expect_v("rst_rval_clr", S_RVAL, 32'h0);
      for (int i = 0; i < 10; i++) begin
         expect_v("clr1_busy", S_BUSY, 32'h1);
         step;
      end
      // reset again at CLEAR cycle 10
      rst = 1'b0;
      expect_v("clr10_busy", S_BUSY, 32'h1);
      step;
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         expect_v("clr2_busy", S_BUSY, 32'h1);
         expect_v("clr2_sbusy", S_SBUSY,
                  (i < 20) ? 32'h1 : 32'h0);
         step;
      end
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd9;
      expect_v("clr2_done", S_BUSY, 32'h0);
      expect_v("clr2_x3", S_RD0, 32'h0);
      expect_v("clr2_x9", S_RD1, 32'h0);
      step;
      step;
      step;
      checks++;
      if (dbg_q.size() != 0) begin
         errors++;
         $display("FAIL dbg_missing got %0d pending required 0",
                  dbg_q.size());
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL exp_unchecked got %0d pending required 0",
                  exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
